seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Parametrised multiplexed 7-segment scan controller, next generation of the team's 4-digit display driver. It drives DIGITS common-anode digits from one packed hex bus, with per-digit decimal point and blanking, leading-zero suppression and PWM brightness. It also double-buffers display data so that updates take effect only at frame boundaries. It sits between user logic and the board's active-low anode/cathode pins.

## Interface
- DIGITS, 4: number of digits scanned; 2..8.
- CLK_DIV, 10000: clk_in cycles per digit slot; ≥ 2.
- BRIGHT_W, 3: brightness control width; PWM period is 2^BRIGHT_W clk_in cycles.

- clk_in  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- digits_in  in  4*DIGITS  hex nibbles; digit k = digits_in[4k+3:4k]; digit 0 is the rightmost.
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- blank_in  in  DIGITS  1 = digit k fully dark, including its DP.
- lz_en  in  1  leading-zero suppression enable.
- bright  in  BRIGHT_W  on-time level; 0 = dimmest, all-ones = 100 %.
- load  in  1  1-cycle strobe; captures digits_in/dp_in/blank_in into the pending buffer.
- an  out  DIGITS  anodes, active-low, one-hot-low or all high.
- cat  out  8  cathodes, active-low; cat[6:0] = segments g..a, cat[7] = DP.
- frame_done  out  1  1-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- Prescaler `pre` counts 0..CLK_DIV-1 and wraps. `tick` is asserted when pre == CLK_DIV-1.
- Scan index `idx` (width clog2(DIGITS), min 1) advances on tick. It wraps from DIGITS-1 to 0; that wrap is the frame boundary.
- Buffering: `load` writes the pending regs and sets pend_v.
  - At a frame boundary with pend_v = 1: pending → active, pend_v cleared.
  - load coincident with the boundary: the new data goes to pending only (applied next frame); pend_v stays 1.
  - Repeated loads within a frame: last one wins.
- Leading-zero suppression (lz_en = 1): digit k, for k ≥ 1, is suppressed iff every active digit j ≥ k has nibble 0, dp 0 and blank 0. Digit 0 is never suppressed.
  - A blanked digit does not break the run of leading zeros.
  - A zero digit with DP lit does break the run.
- Dark digit: blank or suppressed. For a dark digit, cat = 8'hFF and its anode is still driven low in its slot, so timing stays uniform.
- Decode table, cat[6:0] active-low: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E (hex, 7 LSBs). cat[7] = ~dp.
- Brightness: a free-running `pwm` counter of BRIGHT_W bits increments every clk_in. The anode for idx is low only when pwm ≤ bright; otherwise all anodes are high. Duty = (bright+1)/2^BRIGHT_W.
- Ghost guard: on the clk_in cycle right after idx changes, `an` is forced all-high.

## Timing
- Reset values (async): pre = 0, idx = 0, pwm = 0, active regs = 0, pending regs = 0, pend_v = 0, an = all 1, cat = 8'hFF, frame_done = 0.
- an, cat and frame_done are registered. They reflect idx/active state from the previous edge (1-cycle latency).
- Digit slot length = CLK_DIV cycles. Frame = DIGITS*CLK_DIV cycles.
- frame_done is high for exactly 1 cycle: the cycle after the edge at which idx goes DIGITS-1 → 0.
- load-to-display latency: the data appears at the next frame boundary after the load edge, plus 1 cycle. Worst case is DIGITS*CLK_DIV + 1 cycles.
- Changes on bright and lz_en take effect on the next clk_in (no buffering).
- rst mid-frame: all outputs go to reset values immediately, without waiting for a clock. The scan restarts at digit 0 with pre = 0 after release. A pending load is discarded.

## Test plan
- Reset: DIGITS=4, CLK_DIV=4, BRIGHT_W=2, bright=3. Assert rst mid-slot → an=4'hF, cat=8'hFF at once. After release, an walks 1110→1101→1011→0111. Each anode is low for 3 cycles plus 1 guard cycle per 4-cycle slot. frame_done pulses every 16 cycles.
- Buffering: load 16'h1234 once mid-frame → display stays 0000 until the next frame_done. Then digit 0 cat=8'hB0 ('4') and digit 3 cat=8'hF9 ('1'). A second load of 16'hABCD in the same frame → only ABCD is shown.
- Suppression: digits 16'h0050, dp=0, lz_en=1 → digits 3 and 2 dark (cat=FF), digit 1 cat=92, digit 0 cat=C0. dp_in=4'b0100 → digit 2 shows 8'h40 and digit 3 stays dark.
- Blank/DP: blank_in=4'b0010, dp_in=4'b0001, digits 16'h8888 → digit 1 cat=FF, digit 0 cat=8'h00, others cat=8'h80.
- Brightness: bright=0, BRIGHT_W=2 → the active anode is low only in cycles where pwm == 0 (≤ 1 of 4). bright=2 → 3 of 4 cycles, excluding the guard cycle.
- Boundary load: pulse load on the exact cycle idx wraps → new data is not shown this frame; it is shown after the following frame_done.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with frame-synchronous
// double buffering, leading-zero suppression, per-digit DP/blank and PWM dimming.
module seg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int CLK_DIV  = 10000,
  parameter int BRIGHT_W = 3
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            cat,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  // Active-low segment pattern g..a for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BRIGHT_W-1:0] pwm_q;
  logic [4*DIGITS-1:0] act_dig_q, pend_dig_q;
  logic [DIGITS-1:0]   act_dp_q, pend_dp_q;
  logic [DIGITS-1:0]   act_blank_q, pend_blank_q;
  logic                pend_v_q, pend_v_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          cat_q, cat_d;
  logic                frame_done_q;

  logic                tick;
  logic                wrap;
  logic [DIGITS-1:0]   lead_run;
  logic                dark;

  assign tick = (pre_q == PRE_MAX);
  assign wrap = tick && (idx_q == IDX_MAX);

  always_comb begin
    pre_d    = tick ? '0 : pre_q + 1'b1;
    idx_d    = idx_q;
    if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    pend_v_d = load ? 1'b1 : (wrap ? 1'b0 : pend_v_q);
  end

  // A digit belongs to the leading run while it and every digit above it is
  // either blanked or a zero nibble without DP.
  always_comb begin : lead_scan
    logic run;
    // NOTE: in combinational logic, blocking '=' with a default assigned first
    // keeps the block latch-free and lets 'run' carry across loop iterations.
    run      = 1'b1;
    lead_run = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run = run & (act_blank_q[k] | ((act_dig_q[4*k +: 4] == 4'h0) & ~act_dp_q[k]));
      lead_run[k] = run;
    end
  end

  assign dark = act_blank_q[idx_q] | (lz_en & lead_run[idx_q] & (idx_q != '0));

  always_comb begin
    cat_d = dark ? 8'hFF : {~act_dp_q[idx_q], seg_decode(act_dig_q[4*idx_q +: 4])};
    an_d  = '1;
    // The slot boundary cycle keeps all anodes off so the old cathodes never ghost.
    if (!tick && (pwm_q <= bright)) an_d = ~(DIGITS'(1) << idx_q);
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pre_q        <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_v_q     <= 1'b0;
      an_q         <= '1;
      cat_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_q + 1'b1;
      pend_v_q     <= pend_v_d;
      an_q         <= an_d;
      cat_q        <= cat_d;
      frame_done_q <= wrap;
      if (load) begin
        pend_dig_q   <= digits_in;
        pend_dp_q    <= dp_in;
        pend_blank_q <= blank_in;
      end
      if (wrap && pend_v_q) begin
        act_dig_q   <= pend_dig_q;
        act_dp_q    <= pend_dp_q;
        act_blank_q <= pend_blank_q;
      end
    end
  end

  assign an         = an_q;
  assign cat        = cat_q;
  assign frame_done = frame_done_q;

endmodule
